// File: rtl/lvds_pix_mapper_pkg.sv
// Shared types for the LVDS pixel mapper: lane-mapping codes, FSM states, pixel/sync/lane structs.
// Also holds the lane packer so the reset blanking word and the live word come from one place.
package lvds_pix_mapper_pkg;

   localparam int MAP_CODE_VESA  = 0;
   localparam int MAP_CODE_JEIDA = 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SYNC_WAIT = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic de;
      logic vs;
      logic hs;
   } sync_t;

   typedef struct packed {
      logic [6:0] d0;
      logic [6:0] d1;
      logic [6:0] d2;
      logic [6:0] d3;
   } lanes_t;

   // Bit 6 of each lane word is the first bit serialized.
   function automatic lanes_t pack_lanes(input rgb_t px, input sync_t s, input logic jeida);
      lanes_t w;
      if (jeida) begin
         w.d0 = {px.g[2], px.r[7:2]};
         w.d1 = {px.b[3:2], px.g[7:3]};
         w.d2 = {s.de, s.vs, s.hs, px.b[7:4]};
         w.d3 = {1'b0, px.b[1:0], px.g[1:0], px.r[1:0]};
      end else begin
         w.d0 = {px.g[0], px.r[5:0]};
         w.d1 = {px.b[1:0], px.g[5:1]};
         w.d2 = {s.de, s.vs, s.hs, px.b[5:2]};
         w.d3 = {1'b0, px.b[7:6], px.g[7:6], px.r[7:6]};
      end
      return w;
   endfunction

endpackage

// File: rtl/lvds_pix_mapper_timing.sv
// Video timing generator: h/v counters (held at 0 while run=0), DE/HS/VS and frame-origin flag.
// Outputs are combinational from the counter registers; counters advance one pixel per clock.
module lvds_vid_timing #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic de,
   output logic hs,
   output logic vs,
   output logic at_origin
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign de        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs        = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
   assign vs        = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/lvds_pix_mapper.sv
// RGB888 stream to 7:1 LVDS lane words with generated timing; lanes are one register after the counters.
// Backpressure: pix_ready follows DE while running; SOF-hunting drops non-SOF pixels and holds the SOF pixel.
module lvds_pix_mapper
   import lvds_pix_mapper_pkg::*;
#(
   parameter int H_ACTIVE  = 1024,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BP      = 160,
   parameter int V_ACTIVE  = 768,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 29,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int MAP_JEIDA = 0
) (
   input  logic        sclk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [23:0] pix_data,
   input  logic        pix_sof,
   output logic [6:0]  data0,
   output logic [6:0]  data1,
   output logic [6:0]  data2,
   output logic [6:0]  data3,
   output logic        frame_start,
   output logic        underrun,
   output logic        sof_err,
   input  logic        err_clr
);
   localparam logic   JEIDA = (MAP_JEIDA == MAP_CODE_JEIDA);
   localparam lanes_t BLANK = pack_lanes(rgb_t'(24'd0), sync_t'({1'b0, ~VS_POL, ~HS_POL}), JEIDA);

   state_t state, state_nxt;
   logic   de, hs, vs, at_origin;
   logic   fire, misalign, ur_set, emit, cnt_run;
   lanes_t word, lanes_q;

   lvds_vid_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) u_timing (
      .clk      (sclk),
      .rst_n    (reset_n),
      .run      (cnt_run),
      .de       (de),
      .hs       (hs),
      .vs       (vs),
      .at_origin(at_origin)
   );

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      fire      = 1'b0;
      misalign  = 1'b0;
      ur_set    = 1'b0;
      emit      = 1'b0;
      if (!enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_SYNC_WAIT;
            ST_SYNC_WAIT: begin
               pix_ready = pix_valid && !pix_sof;
               if (pix_valid && pix_sof) state_nxt = ST_RUN;
            end
            ST_RUN: begin
               pix_ready = de;
               fire      = de && pix_valid;
               ur_set    = de && !pix_valid;
               // SOF must coincide exactly with the frame origin, else re-hunt.
               misalign  = fire && (pix_sof != at_origin);
               emit      = !misalign;
               if (misalign) state_nxt = ST_SYNC_WAIT;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Counters restart from the origin on every entry into RUN.
   assign cnt_run = (state == ST_RUN) && (state_nxt == ST_RUN);

   assign word = emit ? pack_lanes(rgb_t'(fire ? pix_data : 24'd0), sync_t'({de, vs, hs}), JEIDA)
                      : BLANK;

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         lanes_q     <= BLANK;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         sof_err     <= 1'b0;
      end else begin
         lanes_q     <= word;
         frame_start <= emit && at_origin;
         underrun    <= ur_set | (underrun & ~err_clr);
         sof_err     <= misalign | (sof_err & ~err_clr);
      end
   end

   assign data0 = lanes_q.d0;
   assign data1 = lanes_q.d1;
   assign data2 = lanes_q.d2;
   assign data3 = lanes_q.d3;

endmodule

// File: tb/tb_lvds_pix_mapper.sv
// Bench for lvds_pix_mapper: VESA and JEIDA instances share one stream, checked every cycle against a
// frame-position model, plus hand-computed lane words and flag behaviour.
module tb_lvds_pix_mapper;
   localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
   localparam int VA = 2, VF = 1, VSW = 1, VB = 1;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam bit HSP = 1'b0, VSP = 1'b0;

   logic        sclk = 1'b0, reset_n = 1'b0, enable = 1'b1;
   logic        pix_valid = 1'b0, pix_sof = 1'b0, err_clr = 1'b0;
   logic [23:0] pix_data = '0;
   logic        rdy_v, rdy_j, fs_v, fs_j, ur_v, ur_j, se_v, se_j;
   logic [6:0]  v0, v1, v2, v3, j0, j1, j2, j3;

   always #5 sclk = ~sclk;

   lvds_pix_mapper #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VSW), .V_BP(VB), .HS_POL(HSP), .VS_POL(VSP), .MAP_JEIDA(0)) u_vesa (
      .sclk(sclk), .reset_n(reset_n), .enable(enable), .pix_valid(pix_valid), .pix_ready(rdy_v),
      .pix_data(pix_data), .pix_sof(pix_sof), .data0(v0), .data1(v1), .data2(v2), .data3(v3),
      .frame_start(fs_v), .underrun(ur_v), .sof_err(se_v), .err_clr(err_clr));

   lvds_pix_mapper #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VSW), .V_BP(VB), .HS_POL(HSP), .VS_POL(VSP), .MAP_JEIDA(1)) u_jeida (
      .sclk(sclk), .reset_n(reset_n), .enable(enable), .pix_valid(pix_valid), .pix_ready(rdy_j),
      .pix_data(pix_data), .pix_sof(pix_sof), .data0(j0), .data1(j1), .data2(j2), .data3(j3),
      .frame_start(fs_j), .underrun(ur_j), .sof_err(se_j), .err_clr(err_clr));

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lane words from the mapping tables using plain integer arithmetic.
   function automatic logic [27:0] ref_word(input logic [23:0] px, input bit de, input bit hs,
                                            input bit vs, input bit jeida);
      int r, g, b, d0, d1, d2, d3;
      r = int'(px[23:16]); g = int'(px[15:8]); b = int'(px[7:0]);
      if (!jeida) begin
         d0 = (g % 2) * 64 + r % 64;
         d1 = (b % 4) * 32 + (g / 2) % 32;
         d2 = (b / 4) % 16;
         d3 = (b / 64) * 16 + (g / 64) * 4 + r / 64;
      end else begin
         d0 = ((g / 4) % 2) * 64 + r / 4;
         d1 = ((b / 4) % 4) * 32 + g / 8;
         d2 = b / 16;
         d3 = (b % 4) * 16 + (g % 4) * 4 + r % 4;
      end
      d2 = d2 + int'(de) * 64 + int'(vs) * 32 + int'(hs) * 16;
      return {7'(d0), 7'(d1), 7'(d2), 7'(d3)};
   endfunction

   // Model: mode 0=idle 1=hunting SOF 2=running; m_pos is the linear pixel index within the frame.
   int          m_mode = 0, m_pos = 0, m_h, m_v;
   bit          m_de, m_hs, m_vs, m_first, m_rdy;
   logic [27:0] e_v, e_j;
   logic        e_fs, e_ur, e_se;

   task automatic cmp_out();
      chk("vesa_d0", v0, e_v[27:21]); chk("vesa_d1", v1, e_v[20:14]);
      chk("vesa_d2", v2, e_v[13:7]);  chk("vesa_d3", v3, e_v[6:0]);
      chk("jeida_d0", j0, e_j[27:21]); chk("jeida_d1", j1, e_j[20:14]);
      chk("jeida_d2", j2, e_j[13:7]);  chk("jeida_d3", j3, e_j[6:0]);
      chk("frame_start", fs_v, e_fs); chk("frame_start_j", fs_j, e_fs);
      chk("underrun", ur_v, e_ur);    chk("underrun_j", ur_j, e_ur);
      chk("sof_err", se_v, e_se);     chk("sof_err_j", se_j, e_se);
   endtask

   always @(negedge sclk) begin
      if (!reset_n) begin
         m_mode = 0; m_pos = 0;
         e_v = ref_word(24'd0, 1'b0, !HSP, !VSP, 1'b0);
         e_j = ref_word(24'd0, 1'b0, !HSP, !VSP, 1'b1);
         e_fs = 1'b0; e_ur = 1'b0; e_se = 1'b0;
         cmp_out();
         chk("pix_ready_rst", rdy_v, 1'b0);
      end else begin
         cmp_out();
         m_h = m_pos % HT; m_v = m_pos / HT;
         m_de = (m_h < HA) && (m_v < VA);
         m_hs = (m_h >= HA + HF && m_h < HA + HF + HSW) ? HSP : !HSP;
         m_vs = (m_v >= VA + VF && m_v < VA + VF + VSW) ? VSP : !VSP;
         m_first = (m_pos == 0);
         m_rdy = 1'b0;
         if (enable && m_mode == 1) m_rdy = pix_valid && !pix_sof;
         if (enable && m_mode == 2) m_rdy = m_de;
         chk("pix_ready", rdy_v, m_rdy);
         chk("pix_ready_j", rdy_j, m_rdy);
         e_v = ref_word(24'd0, 1'b0, !HSP, !VSP, 1'b0);
         e_j = ref_word(24'd0, 1'b0, !HSP, !VSP, 1'b1);
         e_fs = 1'b0;
         e_ur = e_ur && !err_clr;
         e_se = e_se && !err_clr;
         if (!enable) begin
            m_mode = 0; m_pos = 0;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (pix_valid && pix_sof) m_mode = 2;
            m_pos = 0;
         end else if (m_de && pix_valid && (pix_sof != m_first)) begin
            e_se = 1'b1; m_mode = 1; m_pos = 0;
         end else begin
            e_v = ref_word((m_de && pix_valid) ? pix_data : 24'd0, m_de, m_hs, m_vs, 1'b0);
            e_j = ref_word((m_de && pix_valid) ? pix_data : 24'd0, m_de, m_hs, m_vs, 1'b1);
            e_fs = m_first;
            if (m_de && !pix_valid) e_ur = 1'b1;
            m_pos = (m_pos + 1) % (HT * VT);
         end
      end
   end

   // Pixel source: each item is held until consumed; gap = idle cycles before it is offered.
   typedef struct {
      logic [23:0] d;
      logic        sof;
      int          gap;
   } item_t;
   item_t       q[$];
   int          gap_cnt = 0, fs_cnt = 0;
   logic        fire_s;
   logic [27:0] fs_lv, fs_lj;

   task automatic drive();
      pix_valid = (q.size() > 0) && (gap_cnt == 0);
      pix_data  = (q.size() > 0) ? q[0].d : 24'd0;
      pix_sof   = (q.size() > 0) ? q[0].sof : 1'b0;
   endtask

   task automatic push(input logic [23:0] d, input logic sof, input int gap);
      item_t it;
      it.d = d; it.sof = sof; it.gap = gap;
      if (q.size() == 0) gap_cnt = gap;
      q.push_back(it);
      drive();
   endtask

   task automatic push_frame(input logic [23:0] first, input int n, input int sof_mask, input int gap_at);
      for (int i = 0; i < n; i++)
         push((i == 0) ? first : 24'($urandom), sof_mask[i], (i == gap_at) ? 1 : 0);
   endtask

   task automatic step();
      @(negedge sclk);
      fire_s = pix_valid && rdy_v;
      if (fs_v) begin
         fs_cnt++;
         fs_lv = {v0, v1, v2, v3};
         fs_lj = {j0, j1, j2, j3};
      end
      @(posedge sclk);
      #1;
      if (fire_s) begin
         void'(q.pop_front());
         if (q.size() > 0) gap_cnt = q[0].gap;
      end else if (gap_cnt > 0) begin
         gap_cnt--;
      end
      drive();
   endtask

   task automatic wait_fs(input int budget);
      int start;
      start = fs_cnt;
      for (int i = 0; i < budget && fs_cnt == start; i++) step();
      if (fs_cnt == start) begin
         total++; bad++;
         $display("FAIL frame_start_timeout: got no pulse in %0d cycles, want one", budget);
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && q.size() > 0; i++) step();
      if (q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pixels left, want 0", q.size());
      end
   endtask

   int off_cnt = 0;

   initial begin
      repeat (3) step();
      chk("rst_d2", v2, 7'b0110000);
      chk("rst_d0", v0, 7'b0000000);
      chk("rst_rdy", rdy_v, 1'b0);
      chk("rst_flags", {fs_v, ur_v, se_v}, 3'b000);
      reset_n = 1'b1;

      push_frame(24'hAABBCC, HA * VA, 1, -1);
      wait_fs(20);
      chk("vesa_aabbcc_d3", fs_lv[6:0], 7'b0111010);
      chk("vesa_aabbcc_d0", fs_lv[27:21], 7'b1101010);
      wait_drain(60);

      push_frame(24'h804020, HA * VA, 1, -1);
      wait_fs(60);
      chk("jeida_804020_d0", fs_lj[27:21], 7'b0100000);
      chk("jeida_804020_d2", fs_lj[13:7], 7'b1110010);
      wait_drain(60);

      // Pixel 2 arrives one cycle late, so line 0 takes only three pixels.
      push_frame(24'h123456, HA * VA - 1, 1, 2);
      wait_drain(80);
      chk("underrun_set", ur_v, 1'b1);
      repeat (3) step();
      chk("underrun_sticky", ur_v, 1'b1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("underrun_clr", ur_v, 1'b0);

      // Misplaced SOF on pixel 2, then a clean frame to realign on.
      push_frame(24'h111111, HA * VA, 32'b101, -1);
      push_frame(24'h222222, HA * VA, 1, -1);
      wait_drain(150);
      chk("sof_err_set", se_v, 1'b1);
      chk("sof_err_no_ur", ur_v, 1'b0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("sof_err_clr", se_v, 1'b0);

      enable = 1'b0; step();
      push(24'hDEAD01, 1'b0, 0);
      push(24'hDEAD02, 1'b0, 0);
      push_frame(24'h333333, HA * VA, 1, -1);
      repeat (2) step();
      chk("idle_rdy", rdy_v, 1'b0);
      enable = 1'b1;
      wait_fs(20);
      chk("resync_d0", fs_lv[27:21], ref_word(24'h333333, 1'b1, 1'b1, 1'b1, 1'b0) >> 21);
      step();
      enable = 1'b0; step();
      chk("en_off_d2", v2, 7'b0110000);
      chk("en_off_rdy", rdy_v, 1'b0);
      enable = 1'b1;
      q.delete(); drive();
      repeat (50) step();
      err_clr = 1'b1; step(); err_clr = 1'b0;

      push_frame(24'h445566, HA * VA, 1, -1);
      wait_fs(60);
      step(); step();
      reset_n = 1'b0;
      #1;
      chk("rst_mid_d2", v2, 7'b0110000);
      chk("rst_mid_d0", v0, 7'b0000000);
      chk("rst_mid_fs", fs_v, 1'b0);
      q.delete(); drive();
      step();
      reset_n = 1'b1;
      step();

      for (int c = 0; c < 3000; c++) begin
         if (q.size() < 4)
            push_frame(24'($urandom), ($urandom_range(0, 7) == 0) ? HA * VA - 1 : HA * VA,
                       ($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, 7)) : 1,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
         err_clr = ($urandom_range(0, 24) == 0);
         if (off_cnt > 0) begin
            off_cnt--;
            enable = 1'b0;
         end else begin
            enable = 1'b1;
            if ($urandom_range(0, 199) == 0) off_cnt = $urandom_range(1, 4);
         end
         reset_n = !($urandom_range(0, 999) == 0);
         step();
      end
      reset_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
